myproject_mul_pipe: RTL and testbench
=====================================

# myproject_mul_pipe

Parametrised, pipelined fixed-point multiplier for the CNN datapath. It takes two operands, each independently signed or unsigned, and forms the exact product. The product is scaled by a right shift, optionally rounded, then wrapped or saturated to the output width. A valid bit travels alongside the data, and a clock enable stalls the whole pipe. It replaces the combinational multiply cells wherever the dense and conv layers need registered products, on-the-fly requantisation, or overflow reporting.

## Interface
- ID, 1: instance tag; no functional effect.
- NUM_STAGE, 2: register stages, legal range 1..4; equals latency in enabled cycles.
- din0_WIDTH, 10: width of operand 0.
- din1_WIDTH, 10: width of operand 1.
- din0_SIGNED, 0: 1 means din0 is two's complement, 0 means unsigned.
- din1_SIGNED, 1: same as din0_SIGNED, for din1.
- dout_WIDTH, 20: output width; range 2..PW.
- SHIFT, 0: arithmetic right shift applied to the product; range 0..PW-1.
- ROUND, 0: 0 truncates (floor); 1 rounds half-up by adding 2^(SHIFT-1) before the shift. ROUND is ignored when SHIFT=0.
- SAT, 0: 0 wraps by keeping the low dout_WIDTH bits; 1 clamps to the output range.
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- ce  in  1  pipeline enable; when low, every register holds its value.
- din_vld  in  1  operands valid this cycle.
- din0  in  din0_WIDTH  operand 0.
- din1  in  din1_WIDTH  operand 1.
- ovf_clr  in  1  clears ovf_sticky.
- dout  out  dout_WIDTH  result.
- dout_vld  out  1  dout is valid.
- ovf  out  1  the result on dout was clamped (SAT=1) or wrapped (SAT=0); qualified by dout_vld.
- ovf_sticky  out  1  set by any valid overflowing result; held until ovf_clr or reset.

## Operation
- **Operand extension:** each operand is extended to width+1 as signed: sign-extended when its SIGNED parameter is 1, zero-extended when it is 0.
- **Product:** exact signed product of width PW = din0_WIDTH + din1_WIDTH + 2. It never overflows.
- **Output signedness:** OSGN = din0_SIGNED | din1_SIGNED. The output is two's complement when OSGN=1 and unsigned when OSGN=0.
- **Scaling:** r = (P + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT. The intermediate is wide enough that adding the rounding constant cannot overflow.
- **Range fit, OSGN=1:**
  - Range is [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
  - SAT=1: out-of-range values are clamped to the nearest bound.
  - SAT=0: keep r[dout_WIDTH-1:0].
  - ovf=1 whenever r is outside the range, in either SAT mode.
- **Range fit, OSGN=0:**
  - Range is [0, 2^dout_WIDTH-1].
  - SAT=1: values above the range clamp to the maximum.
  - SAT=0: low bits are kept, as for OSGN=1.
  - ovf=1 whenever r is above the range.
- **Stage mapping:**
  - NUM_STAGE=1: output register only.
  - NUM_STAGE=2: operand registers, then output register.
  - NUM_STAGE=3: adds a product register between them.
  - NUM_STAGE=4: adds a scaled-value register after the product register.
- **Valid chain:** a valid bit accompanies every stage. Data registers load on every enabled cycle, whatever the valid bit. Downstream logic qualifies data only with dout_vld.
- **ovf_sticky:** set on an enabled cycle in which the output stage loads a valid result with overflow. ovf_clr clears it. When set and clear occur in the same cycle, set wins.

## Timing
- **Reset:** ap_rst=1 at a clock edge clears every data register, every valid bit, ovf, and ovf_sticky to 0. Reset overrides ce. Samples in flight are discarded, and dout_vld is 0 from the first edge after reset asserts.
- **Latency:** a sample presented at edge k with ce=1 appears at dout, with dout_vld=1, after edge k+NUM_STAGE-1. The output is registered, so dout is visible NUM_STAGE edges after capture.
- **Throughput:** one sample per enabled cycle. No bubbles are inserted.
- **Stall:** ce=0 freezes all registers, including dout, dout_vld, and ovf; inputs during a stall are ignored. Latency counts enabled edges only. ovf_clr acts regardless of ce.
- **Output hold:** outputs are stable between enabled edges.

## Test plan
- **Default parameters, full range:** din0=1023, din1=-512 -> dout=-523776 (0x80200), ovf=0. din0=1023, din1=511 -> 522753, ovf=0. Both appear 2 enabled cycles after capture.
- **Round and saturate:** dout_WIDTH=8, SHIFT=4, ROUND=1, SAT=1.
  - din0=10, din1=-7 -> -4, ovf=0.
  - din0=100, din1=50 -> 127, ovf=1, ovf_sticky=1.
- **Wrap:** same configuration with SAT=0, din0=100, din1=50 -> r=313 -> dout=0x39 (57), ovf=1.
- **Streaming with stalls, NUM_STAGE=4:** send 8 back-to-back samples with ce toggling pseudo-randomly. Results must appear in order, with correct values, each exactly 4 enabled edges after capture. dout must hold whenever ce=0.
- **Reset mid-flight and sticky precedence:**
  - Assert ap_rst with 3 samples in the pipe: dout_vld=0 and dout=0 on the next edge, and nothing emerges afterward.
  - Assert ovf_clr in the same cycle that an overflowing valid result loads: ovf_sticky stays 1.
- **Unsigned corner:** din0_SIGNED=din1_SIGNED=0, widths 4/4, dout_WIDTH=6, SAT=1. din0=15, din1=15 -> 63, ovf=1. din0=7, din1=9 -> 63, ovf=0.

Source files
------------

// File: rtl/myproject_mul_pipe.sv
// myproject_mul_pipe: pipelined fixed-point multiplier with shift scaling,
// optional half-up rounding, wrap or saturate, and overflow flags.
// Ports: ap_clk/ap_rst clock and sync active-high reset, ce pipe enable,
//   din_vld/din0/din1 operands in, ovf_clr clears ovf_sticky,
//   dout/dout_vld/ovf registered result, ovf_sticky latched overflow.
module myproject_mul_pipe #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 2,
  parameter int din0_WIDTH  = 10,
  parameter int din1_WIDTH  = 10,
  parameter int din0_SIGNED = 0,
  parameter int din1_SIGNED = 1,
  parameter int dout_WIDTH  = 20,
  parameter int SHIFT       = 0,
  parameter int ROUND       = 0,
  parameter int SAT         = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  din_vld,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  ovf_clr,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic                  ovf,
  output logic                  ovf_sticky
);

  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int DW = dout_WIDTH;
  localparam int PW = W0 + W1 + 2;
  localparam int RW = PW + 1;
  localparam bit OSGN = (din0_SIGNED != 0) || (din1_SIGNED != 0);
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [RW-1:0] ONE = RW'(1);
  localparam logic [RW-1:0] RC =
    (ROUND != 0 && SHIFT > 0) ? (ONE << RS) : '0;
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] UMAX = '1;

  logic unused_id;
  assign unused_id = (ID != 0);

  // Both operands become signed W+1 so one signed multiply covers
  // every signedness mix.
  logic signed [W0:0] a0;
  logic signed [W1:0] b0;
  assign a0 = (din0_SIGNED != 0) ? {din0[W0-1], din0} : {1'b0, din0};
  assign b0 = (din1_SIGNED != 0) ? {din1[W1-1], din1} : {1'b0, din1};

  logic signed [W0:0] a1;
  logic signed [W1:0] b1;
  logic               v1;

  if (NUM_STAGE >= 2) begin : g_op
    logic signed [W0:0] a_q;
    logic signed [W1:0] b_q;
    logic               v_q;
    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        a_q <= '0;
        b_q <= '0;
        v_q <= 1'b0;
      end else if (ce) begin
        a_q <= a0;
        b_q <= b0;
        v_q <= din_vld;
      end
    end
    assign a1 = a_q;
    assign b1 = b_q;
    assign v1 = v_q;
  end else begin : g_op_byp
    assign a1 = a0;
    assign b1 = b0;
    assign v1 = din_vld;
  end

  logic signed [PW-1:0] ax;
  logic signed [PW-1:0] bx;
  logic signed [PW-1:0] prod_d;
  assign ax     = PW'(a1);
  assign bx     = PW'(b1);
  assign prod_d = ax * bx;

  logic signed [PW-1:0] p2;
  logic                 v2;

  if (NUM_STAGE >= 3) begin : g_prod
    logic signed [PW-1:0] p_q;
    logic                 v_q;
    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        p_q <= '0;
        v_q <= 1'b0;
      end else if (ce) begin
        p_q <= prod_d;
        v_q <= v1;
      end
    end
    assign p2 = p_q;
    assign v2 = v_q;
  end else begin : g_prod_byp
    assign p2 = prod_d;
    assign v2 = v1;
  end

  // One extra bit so the rounding add can never carry out.
  logic signed [RW-1:0] sum_d;
  logic signed [RW-1:0] r_d;
  assign sum_d = {p2[PW-1], p2} + RC;
  assign r_d   = sum_d >>> SHIFT;

  logic signed [RW-1:0] r3;
  logic                 v3;

  if (NUM_STAGE >= 4) begin : g_scl
    logic signed [RW-1:0] r_q;
    logic                 v_q;
    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        r_q <= '0;
        v_q <= 1'b0;
      end else if (ce) begin
        r_q <= r_d;
        v_q <= v2;
      end
    end
    assign r3 = r_q;
    assign v3 = v_q;
  end else begin : g_scl_byp
    assign r3 = r_d;
    assign v3 = v2;
  end

  // In range iff the bits above the kept field are pure sign
  // (signed) or all zero (unsigned).
  logic signed [RW-1:0] hi_s;
  logic signed [RW-1:0] hi_u;
  logic [DW-1:0]        dout_d;
  logic                 ovf_d;
  assign hi_s = r3 >>> (DW - 1);
  assign hi_u = r3 >>> DW;

  always_comb begin
    dout_d = r3[DW-1:0];
    ovf_d  = 1'b0;
    if (OSGN) begin
      ovf_d = (hi_s != '0) && (hi_s != '1);
    end else begin
      ovf_d = !r3[RW-1] && (hi_u != '0);
    end
    if (SAT != 0 && ovf_d) begin
      if (!OSGN) begin
        dout_d = UMAX;
      end else if (r3[RW-1]) begin
        dout_d = SMIN;
      end else begin
        dout_d = SMAX;
      end
    end
  end

  logic [DW-1:0] dout_q;
  logic          vld_q;
  logic          ovf_q;
  logic          stk_q;

  // Sticky set beats a same-cycle clear; the clear ignores ce.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
      stk_q  <= 1'b0;
    end else begin
      if (ce) begin
        dout_q <= dout_d;
        vld_q  <= v3;
        ovf_q  <= ovf_d;
      end
      if (ce && v3 && ovf_d) begin
        stk_q <= 1'b1;
      end else if (ovf_clr) begin
        stk_q <= 1'b0;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = vld_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = stk_q;

endmodule

// File: tb/tb_myproject_mul_pipe.sv
// tb_myproject_mul_pipe: six configurations of the multiplier driven
// together and compared every edge against an arithmetic model.
module tb_myproject_mul_pipe;

  localparam int ND = 6;
  localparam int HN = 1024;
  localparam int N_[ND]   = '{2, 2, 2, 4, 3, 1};
  localparam int W0_[ND]  = '{10, 10, 10, 10, 4, 8};
  localparam int W1_[ND]  = '{10, 10, 10, 10, 4, 6};
  localparam int S0_[ND]  = '{0, 0, 0, 1, 0, 1};
  localparam int S1_[ND]  = '{1, 1, 1, 1, 0, 0};
  localparam int DW_[ND]  = '{20, 8, 8, 12, 6, 10};
  localparam int SH_[ND]  = '{0, 4, 4, 3, 0, 2};
  localparam int RND_[ND] = '{0, 1, 1, 1, 0, 0};
  localparam int SAT_[ND] = '{0, 1, 0, 1, 1, 0};

  logic clk;
  logic rst;
  logic ce;
  logic vld;
  logic clr;
  logic [31:0] a_in [ND];
  logic [31:0] b_in [ND];
  logic [31:0] dout_w [ND];
  logic [ND-1:0] vld_w;
  logic [ND-1:0] ovf_w;
  logic [ND-1:0] stk_w;

  int n_vec = 0;
  int n_bad = 0;
  int n = 0;
  bit hv [HN];
  logic [31:0] ha [ND][HN];
  logic [31:0] hb [ND][HN];
  bit stk_m [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic [DW_[g]-1:0] d;
    myproject_mul_pipe #(
      .ID(g),
      .NUM_STAGE(N_[g]),
      .din0_WIDTH(W0_[g]),
      .din1_WIDTH(W1_[g]),
      .din0_SIGNED(S0_[g]),
      .din1_SIGNED(S1_[g]),
      .dout_WIDTH(DW_[g]),
      .SHIFT(SH_[g]),
      .ROUND(RND_[g]),
      .SAT(SAT_[g])
    ) u_dut (
      .ap_clk(clk),
      .ap_rst(rst),
      .ce(ce),
      .din_vld(vld),
      .din0(a_in[g][W0_[g]-1:0]),
      .din1(b_in[g][W1_[g]-1:0]),
      .ovf_clr(clr),
      .dout(d),
      .dout_vld(vld_w[g]),
      .ovf(ovf_w[g]),
      .ovf_sticky(stk_w[g])
    );
    assign dout_w[g] = 32'(d);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic: value, scale, range test, clamp or wrap.
  function automatic void model(input int g, input logic [31:0] a,
                                input logic [31:0] b,
                                output longint d, output bit o);
    longint one = 1;
    longint va, vb, p, r, lo, hi;
    va = longint'(a) & ((one << W0_[g]) - 1);
    vb = longint'(b) & ((one << W1_[g]) - 1);
    if (S0_[g] != 0 && va[W0_[g]-1]) va = va - (one << W0_[g]);
    if (S1_[g] != 0 && vb[W1_[g]-1]) vb = vb - (one << W1_[g]);
    p = va * vb;
    if (RND_[g] != 0 && SH_[g] > 0) p = p + (one << (SH_[g] - 1));
    r = p >>> SH_[g];
    if (S0_[g] != 0 || S1_[g] != 0) begin
      lo = -(one << (DW_[g] - 1));
      hi = (one << (DW_[g] - 1)) - 1;
      o = (r < lo) || (r > hi);
    end else begin
      lo = 0;
      hi = (one << DW_[g]) - 1;
      o = r > hi;
    end
    d = r;
    if (SAT_[g] != 0 && o) d = (r > hi) ? hi : lo;
    d = d & ((one << DW_[g]) - 1);
  endfunction

  task automatic tick();
    longint d;
    bit o;
    bit v;
    int idx;
    @(posedge clk);
    if (rst) begin
      n = 0;
    end else if (ce && n < HN) begin
      hv[n] = vld;
      for (int g = 0; g < ND; g++) begin
        ha[g][n] = a_in[g];
        hb[g][n] = b_in[g];
      end
      n++;
    end
    #1;
    for (int g = 0; g < ND; g++) begin
      idx = n - N_[g];
      d = 0;
      o = 1'b0;
      v = 1'b0;
      if (idx >= 0) begin
        model(g, ha[g][idx], hb[g][idx], d, o);
        v = hv[idx];
      end
      if (rst) stk_m[g] = 1'b0;
      else if (ce && v && o) stk_m[g] = 1'b1;
      else if (clr) stk_m[g] = 1'b0;
      chk($sformatf("d%0d_dout", g), longint'(dout_w[g]), d);
      chk($sformatf("d%0d_vld", g), longint'(vld_w[g]), longint'(v));
      chk($sformatf("d%0d_ovf", g), longint'(ovf_w[g]), longint'(o));
      chk($sformatf("d%0d_stk", g), longint'(stk_w[g]),
          longint'(stk_m[g]));
    end
  endtask

  task automatic zero_in();
    for (int g = 0; g < ND; g++) begin
      a_in[g] = '0;
      b_in[g] = '0;
    end
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    vld = 1'b0;
    clr = 1'b0;
    zero_in();
    tick();
    tick();
    rst = 1'b0;

    vld = 1'b1;
    a_in[0] = 32'd1023;
    b_in[0] = 32'(-512);
    a_in[1] = 32'd10;
    b_in[1] = 32'(-7);
    a_in[2] = 32'd100;
    b_in[2] = 32'd50;
    a_in[4] = 32'd15;
    b_in[4] = 32'd15;
    tick();
    chk("lat_d0_vld", longint'(vld_w[0]), 0);
    a_in[0] = 32'd1023;
    b_in[0] = 32'd511;
    a_in[1] = 32'd100;
    b_in[1] = 32'd50;
    a_in[4] = 32'd7;
    b_in[4] = 32'd9;
    tick();
    chk("dflt_neg", longint'(dout_w[0]), 32'h80200);
    chk("dflt_neg_ovf", longint'(ovf_w[0]), 0);
    chk("rnd_neg", longint'(dout_w[1]), 8'hFC);
    chk("wrap_val", longint'(dout_w[2]), 57);
    chk("wrap_ovf", longint'(ovf_w[2]), 1);
    vld = 1'b0;
    zero_in();
    tick();
    chk("dflt_pos", longint'(dout_w[0]), 522753);
    chk("sat_val", longint'(dout_w[1]), 127);
    chk("sat_ovf", longint'(ovf_w[1]), 1);
    chk("sat_stk", longint'(stk_w[1]), 1);
    chk("uns_sat", longint'(dout_w[4]), 63);
    chk("uns_sat_ovf", longint'(ovf_w[4]), 1);
    tick();
    chk("uns_fit", longint'(dout_w[4]), 63);
    chk("uns_fit_ovf", longint'(ovf_w[4]), 0);

    clr = 1'b1;
    tick();
    chk("clr_stk", longint'(stk_w[1]), 0);
    clr = 1'b0;
    vld = 1'b1;
    a_in[1] = 32'd100;
    b_in[1] = 32'd50;
    tick();
    vld = 1'b0;
    zero_in();
    clr = 1'b1;
    tick();
    chk("set_wins", longint'(stk_w[1]), 1);
    tick();
    chk("clr_after", longint'(stk_w[1]), 0);
    clr = 1'b0;

    vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < ND; g++) begin
        a_in[g] = $urandom;
        b_in[g] = $urandom;
      end
      tick();
    end
    rst = 1'b1;
    tick();
    chk("rst_vld", longint'(vld_w[3]), 0);
    chk("rst_dout", longint'(dout_w[3]), 0);
    rst = 1'b0;
    vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_drain", longint'(vld_w[3]), 0);
    end

    for (int i = 0; i < 400; i++) begin
      ce  = ($urandom_range(0, 2) != 0);
      vld = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      for (int g = 0; g < ND; g++) begin
        a_in[g] = $urandom;
        b_in[g] = $urandom;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
